// File: rtl/cnn_pkg.sv
// Shared CNN pipeline definitions: frame geometry, pixel type and frame_loader FSM states.
package cnn_pkg;

   localparam int DATA_W   = 16;
   localparam int IMG_ROWS = 28;
   localparam int IMG_COLS = 28;
   localparam int PIX_CNT  = IMG_ROWS * IMG_COLS;

   typedef logic signed [DATA_W-1:0] pix_t;

   typedef enum logic {
      FILL_S,
      FULL_S
   } fill_st_e;

   typedef enum logic [1:0] {
      IDLE_S,
      LAUNCH_S,
      RUN_S
   } launch_st_e;

endpackage

// File: rtl/frame_bank.sv
// One frame of pixel storage: simple write port plus a registered read port that
// returns zero for reads flagged out of range.
module frame_bank #(
   parameter int DATA_W = cnn_pkg::DATA_W,
   parameter int DEPTH  = cnn_pkg::PIX_CNT,
   parameter int ADDR_W = $clog2(DEPTH)
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     we_i,
   input  logic [ADDR_W-1:0]        waddr_i,
   input  logic signed [DATA_W-1:0] wdata_i,
   input  logic                     re_i,
   input  logic [ADDR_W-1:0]        raddr_i,
   output logic signed [DATA_W-1:0] rdata_o
);

   (* ram_style = "block" *) logic signed [DATA_W-1:0] mem_q [DEPTH];
   logic signed [DATA_W-1:0] rdata_q;

   always_ff @(posedge clk) begin
      if (we_i) begin
         mem_q[waddr_i] <= wdata_i;
      end
   end

   // Only the output register is reset; the array contents survive reset.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         rdata_q <= '0;
      end else begin
         rdata_q <= re_i ? mem_q[raddr_i] : '0;
      end
   end

   assign rdata_o = rdata_q;

endmodule

// File: rtl/frame_loader.sv
// Buffers a raster-ordered frame, launches the pipeline with start and serves its reads.
// FRAME_LOADER_PINGPONG_EN adds a second bank so the next frame fills while one runs.
module frame_loader #(
   parameter int DATA_W   = cnn_pkg::DATA_W,
   parameter int IMG_ROWS = cnn_pkg::IMG_ROWS,
   parameter int IMG_COLS = cnn_pkg::IMG_COLS
) (
   input  logic                        clk,
   input  logic                        rst,
   input  logic                        s_valid,
   output logic                        s_ready,
   input  logic signed [DATA_W-1:0]    s_data,
   input  logic                        s_last,
   output logic                        start,
   input  logic                        pipe_done,
   input  logic [$clog2(IMG_ROWS)-1:0] rd_row,
   input  logic [$clog2(IMG_COLS)-1:0] rd_col,
   output logic signed [DATA_W-1:0]    rd_data,
   output logic                        busy,
   output logic                        frame_err
);
   import cnn_pkg::*;

   localparam int PIX_N  = IMG_ROWS * IMG_COLS;
   localparam int ADDR_W = $clog2(PIX_N);
   localparam int ROW_W  = $clog2(IMG_ROWS);
   localparam int COL_W  = $clog2(IMG_COLS);
   localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(PIX_N - 1);

   fill_st_e          fill_st_q, fill_st_d;
   launch_st_e        launch_st_q;
   logic [ADDR_W-1:0] wr_cnt_q;
   logic              s_ready_q, start_q, busy_q, frame_err_q, done_prev_q;

   logic              xfer, at_last, commit, done_edge, free_go, launch_go;
   logic              we0, rd_ok;
   logic [ADDR_W-1:0] rd_addr;
   logic signed [DATA_W-1:0] rdata0;

   assign xfer      = s_valid && s_ready_q;
   assign at_last   = (wr_cnt_q == LAST_ADDR);
   assign commit    = xfer && at_last && s_last;
   assign done_edge = pipe_done && !done_prev_q;
   assign free_go   = (launch_st_q == RUN_S) && done_edge;
   assign launch_go = (launch_st_q == IDLE_S) && ((fill_st_q == FULL_S) || commit);

   assign rd_ok   = ({1'b0, rd_row} < (ROW_W + 1)'(IMG_ROWS)) &&
                    ({1'b0, rd_col} < (COL_W + 1)'(IMG_COLS));
   assign rd_addr = ADDR_W'(rd_row) * ADDR_W'(IMG_COLS) + ADDR_W'(rd_col);

`ifdef FRAME_LOADER_PINGPONG_EN
   logic fill_bank_q, act_bank_q, we1;
   logic signed [DATA_W-1:0] rdata1;

   assign we0 = xfer && !fill_bank_q;
   assign we1 = xfer && fill_bank_q;

   frame_bank #(.DATA_W(DATA_W), .DEPTH(PIX_N)) u_bank1 (
      .clk(clk), .rst(rst), .we_i(we1), .waddr_i(wr_cnt_q), .wdata_i(s_data),
      .re_i(rd_ok), .raddr_i(rd_addr), .rdata_o(rdata1)
   );

   assign rd_data = act_bank_q ? rdata1 : rdata0;
`else
   assign we0     = xfer;
   assign rd_data = rdata0;
`endif

   frame_bank #(.DATA_W(DATA_W), .DEPTH(PIX_N)) u_bank0 (
      .clk(clk), .rst(rst), .we_i(we0), .waddr_i(wr_cnt_q), .wdata_i(s_data),
      .re_i(rd_ok), .raddr_i(rd_addr), .rdata_o(rdata0)
   );

   // With two banks a launch hands the full bank over and filling resumes on the other one.
   always_comb begin
      fill_st_d = fill_st_q;
      if ((fill_st_q == FILL_S) && commit) fill_st_d = FULL_S;
`ifdef FRAME_LOADER_PINGPONG_EN
      if (launch_go) fill_st_d = FILL_S;
`else
      if ((fill_st_q == FULL_S) && free_go) fill_st_d = FILL_S;
`endif
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         fill_st_q   <= FILL_S;
         launch_st_q <= IDLE_S;
         wr_cnt_q    <= '0;
         s_ready_q   <= 1'b0;
         start_q     <= 1'b0;
         busy_q      <= 1'b0;
         frame_err_q <= 1'b0;
         done_prev_q <= 1'b0;
`ifdef FRAME_LOADER_PINGPONG_EN
         fill_bank_q <= 1'b0;
         act_bank_q  <= 1'b0;
`endif
      end else begin
         done_prev_q <= pipe_done;
         fill_st_q   <= fill_st_d;
         s_ready_q   <= (fill_st_d == FILL_S);
         start_q     <= 1'b0;
         frame_err_q <= xfer && (at_last != s_last);
         if (xfer) begin
            wr_cnt_q <= (at_last || s_last) ? '0 : wr_cnt_q + 1'b1;
         end
         case (launch_st_q)
            IDLE_S: begin
               if (launch_go) begin
                  launch_st_q <= LAUNCH_S;
                  start_q     <= 1'b1;
                  busy_q      <= 1'b1;
`ifdef FRAME_LOADER_PINGPONG_EN
                  act_bank_q  <= fill_bank_q;
                  fill_bank_q <= !fill_bank_q;
`endif
               end
            end
            LAUNCH_S: launch_st_q <= RUN_S;
            RUN_S: begin
               if (done_edge) begin
                  launch_st_q <= IDLE_S;
                  busy_q      <= 1'b0;
               end
            end
            default: launch_st_q <= IDLE_S;
         endcase
      end
   end

   assign s_ready   = s_ready_q;
   assign start     = start_q;
   assign busy      = busy_q;
   assign frame_err = frame_err_q;

endmodule

// File: tb/tb_frame_loader.sv
// Randomised bench for frame_loader against a frame-level reference model (honours FRAME_LOADER_PINGPONG_EN).
module tb_frame_loader;

   localparam int PIX = 784;

   logic clk = 1'b0;
   logic rst = 1'b1;
   logic s_valid = 1'b0;
   logic s_last = 1'b0;
   logic pipe_done = 1'b0;
   logic signed [15:0] s_data = '0;
   logic [4:0] rd_row = '0;
   logic [4:0] rd_col = '0;
   logic s_ready, start, busy, frame_err;
   logic signed [15:0] rd_data;

   frame_loader dut (
      .clk(clk), .rst(rst), .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data),
      .s_last(s_last), .start(start), .pipe_done(pipe_done), .rd_row(rd_row),
      .rd_col(rd_col), .rd_data(rd_data), .busy(busy), .frame_err(frame_err)
   );

   always #5 clk = ~clk;

   int checks = 0;
   int failures = 0;

   // Reference model: pixels of the frame being filled, the frame waiting for launch,
   // and the frame the pipeline is working on.
   int m_fill [PIX];
   int m_pend [PIX];
   int m_act  [PIX];
   int m_cnt = 0;
   bit m_busy = 0;
   bit m_pending = 0;
   bit pd_prev = 0;
   int run_cnt = 0;
   int run_len = 40;
   bit done_on_commit = 0;
   bit rd_fixed = 0;

   task automatic check(string tag, int got, int exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
      end
   endtask

   task automatic tick(output bit xf);
      bit dedge, commit, err, st_exp, free, rd_chk;
      int r, c, rd_exp;
      xf = s_valid && s_ready;
      if (m_busy) run_cnt++;
      pipe_done = m_busy && ((run_cnt >= run_len) ||
                  (done_on_commit && xf && s_last && (m_cnt == PIX - 1)));
      dedge = pipe_done && !pd_prev;
      if (!rd_fixed) begin
         rd_row = 5'($urandom_range(0, 31));
         rd_col = 5'($urandom_range(0, 31));
      end
      r = int'(rd_row);
      c = int'(rd_col);
      rd_chk = m_busy || r >= 28 || c >= 28;
      rd_exp = (r < 28 && c < 28) ? m_act[r * 28 + c] : 0;
      @(posedge clk);
      #1;
      pd_prev = pipe_done;
      commit = xf && (m_cnt == PIX - 1) && s_last;
      err    = xf && ((m_cnt == PIX - 1) != s_last);
      if (xf) begin
         m_fill[m_cnt] = int'(s_data);
         m_cnt = (commit || err) ? 0 : m_cnt + 1;
      end
      st_exp = !m_busy && (m_pending || commit);
      free   = m_busy && dedge;
      if (st_exp) begin
         if (commit) m_act = m_fill;
         else m_act = m_pend;
         m_pending = 0;
         m_busy = 1;
         run_cnt = 0;
      end else if (commit) begin
         m_pend = m_fill;
         m_pending = 1;
      end
      if (free) m_busy = 0;
      check("start", int'(start), int'(st_exp));
      check("frame_err", int'(frame_err), int'(err));
      check("busy", int'(busy), int'(m_busy));
`ifdef FRAME_LOADER_PINGPONG_EN
      check("s_ready", int'(s_ready), int'(!m_pending));
`else
      check("s_ready", int'(s_ready), int'(!(m_pending || m_busy)));
`endif
      if (rd_chk) check("rd_data", int'(rd_data), rd_exp);
   endtask

   task automatic check_reset_outputs();
      check("rst_s_ready", int'(s_ready), 0);
      check("rst_start", int'(start), 0);
      check("rst_busy", int'(busy), 0);
      check("rst_frame_err", int'(frame_err), 0);
      check("rst_rd_data", int'(rd_data), 0);
   endtask

   task automatic do_reset();
      s_valid = 0;
      s_last = 0;
      pipe_done = 0;
      #2 rst = 1'b1;
      #1 check_reset_outputs();
      m_cnt = 0;
      m_busy = 0;
      m_pending = 0;
      pd_prev = 0;
      run_cnt = 0;
      repeat (2) @(posedge clk);
      #1 rst = 1'b0;
   endtask

   task automatic send_frame(int n, int last_at, bit seq);
      bit xf;
      int guard;
      for (int i = 0; i < n; i++) begin
         if ($urandom_range(0, 7) == 0) tick(xf);
         s_valid = 1'b1;
         s_data  = seq ? 16'(i) : 16'($urandom_range(0, 65535));
         s_last  = (i == last_at);
         xf = 0;
         guard = 0;
         while (!xf && guard < 10000) begin
            tick(xf);
            guard++;
         end
         s_valid = 1'b0;
         s_last = 1'b0;
         if (!xf) begin
            check("xfer_timeout", int'(s_ready), 1);
            return;
         end
      end
   endtask

   task automatic wait_idle();
      bit xf;
      int guard = 0;
      while ((m_busy || m_pending) && guard < 20000) begin
         tick(xf);
         guard++;
      end
      if (m_busy || m_pending) check("idle_timeout", int'(busy), 0);
      repeat (3) tick(xf);
   endtask

   initial begin
      bit xf;
      #2 check_reset_outputs();
      repeat (2) @(posedge clk);
      #1 rst = 1'b0;

      // single frame 0..783, then a directed read of the last pixel
      run_len = 40;
      send_frame(PIX, PIX - 1, 1'b1);
      rd_fixed = 1;
      rd_row = 5'd27;
      rd_col = 5'd27;
      tick(xf);
      check("rd_27_27", int'(rd_data), 783);
      rd_fixed = 0;
      wait_idle();

      // early s_last, then a good frame
      send_frame(501, 500, 1'b0);
      send_frame(PIX, PIX - 1, 1'b0);
      wait_idle();

      // missing s_last, then resync at index 0
      send_frame(PIX, -1, 1'b0);
      send_frame(PIX, PIX - 1, 1'b0);
      rd_fixed = 1;
      rd_row = 5'd0;
      rd_col = 5'd0;
      tick(xf);
      rd_fixed = 0;
      wait_idle();

      // back-to-back frames with a long pipeline
      run_len = 2000;
      send_frame(PIX, PIX - 1, 1'b0);
      send_frame(PIX, PIX - 1, 1'b0);
      wait_idle();

`ifdef FRAME_LOADER_PINGPONG_EN
      // second commit lands on the same cycle as the pipe_done edge
      run_len = 1000000;
      send_frame(PIX, PIX - 1, 1'b0);
      done_on_commit = 1;
      send_frame(PIX, PIX - 1, 1'b0);
      done_on_commit = 0;
      run_len = 20;
      wait_idle();
`endif

      // reset mid-frame and mid-run, then a clean frame
      run_len = 100;
      send_frame(300, -1, 1'b0);
      do_reset();
      send_frame(PIX, PIX - 1, 1'b0);
      repeat (10) tick(xf);
      do_reset();
      send_frame(PIX, PIX - 1, 1'b0);
      wait_idle();

      // random pipeline latencies
      for (int f = 0; f < 3; f++) begin
         run_len = $urandom_range(2, 60);
         send_frame(PIX, PIX - 1, 1'b0);
      end
      wait_idle();

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
